pool_pe_row: RTL and testbench

//  Row of pooling PEs directly downstream of the pooling array controller. Consumes per-beat lane

---
 rtl/pool_pe_row.sv | 137 +++++++++++++
 tb/tb_pool_pe_row.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pool_pe_row.sv
// pool_pe_row: row of pooling PEs fed by the pooling array controller.
// Each lane keeps SLOTS time-multiplexed accumulators and performs a
// read-modify-write per valid beat: max (signed) or running sum (wrapping).
// A result vector for a slot leaves on the beat that carries end; averages
// leave as raw sums, scaling happens downstream.
//
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   xs           LANES signed int8 elements, lane i at [i*8+:8]
//   cmd          {end, max, avg, start}; max|avg marks a valid beat
//   sel          slot of this beat (accumulator read address)
//   sel_delay    sel one cycle late (accumulator write address)
//   out_vld      one-cycle result pulse
//   out_sel      slot of the result
//   out_is_max   1: max result, 0: raw sum
//   out_data     LANES signed ACC_W results, lane i at [i*ACC_W+:ACC_W]
//
// Build option: define POOL_PE_OUT_REG_EN to add one output register stage
// (latency cmd->out_vld becomes 3 cycles instead of 2).

module pool_pe_row #(
  parameter int unsigned LANES = 16,
  parameter int unsigned SLOTS = 4,
  parameter int unsigned ACC_W = 24
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [LANES*8-1:0]          xs,
  input  logic [3:0]                  cmd,
  input  logic [$clog2(SLOTS)-1:0]    sel,
  input  logic [$clog2(SLOTS)-1:0]    sel_delay,
  output logic                        out_vld,
  output logic [$clog2(SLOTS)-1:0]    out_sel,
  output logic                        out_is_max,
  output logic [LANES*ACC_W-1:0]      out_data
);

  localparam int unsigned SEL_W = $clog2(SLOTS);
  localparam int unsigned CMD_START = 0;
  localparam int unsigned CMD_AVG   = 1;
  localparam int unsigned CMD_MAX   = 2;
  localparam int unsigned CMD_END   = 3;

  logic [LANES*8-1:0]        x_q;
  logic [3:0]                cmd_q;
  logic signed [ACC_W-1:0]   acc     [SLOTS][LANES];
  logic signed [ACC_W-1:0]   acc_rd  [LANES];
  logic signed [ACC_W-1:0]   x_ext   [LANES];
  logic signed [ACC_W-1:0]   new_acc [LANES];
  logic                      beat_vld;
  logic                      beat_end;

  logic                      res_vld;
  logic [SEL_W-1:0]          res_sel;
  logic                      res_is_max;
  logic [LANES*ACC_W-1:0]    res_data;

  // Stage 1: capture beat and read the addressed slot of every lane.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q   <= '0;
      cmd_q <= '0;
      for (int l = 0; l < int'(LANES); l++) acc_rd[l] <= '0;
    end else begin
      x_q   <= xs;
      cmd_q <= cmd;
      for (int l = 0; l < int'(LANES); l++) acc_rd[l] <= acc[sel][l];
    end
  end

  // Stage 2 datapath: start reloads, max beats avg when both are set.
  always_comb begin
    beat_vld = cmd_q[CMD_MAX] | cmd_q[CMD_AVG];
    beat_end = beat_vld & cmd_q[CMD_END];
    for (int l = 0; l < int'(LANES); l++) begin
      x_ext[l]   = ACC_W'($signed(x_q[l*8 +: 8]));
      new_acc[l] = x_ext[l];
      if (cmd_q[CMD_START]) begin
        new_acc[l] = x_ext[l];
      end else if (cmd_q[CMD_MAX]) begin
        new_acc[l] = (acc_rd[l] > x_ext[l]) ? acc_rd[l] : x_ext[l];
      end else begin
        new_acc[l] = acc_rd[l] + x_ext[l];
      end
    end
  end

  // Stage 2 write-back; the write address is the stage-1 sel, supplied late.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < int'(SLOTS); s++)
        for (int l = 0; l < int'(LANES); l++) acc[s][l] <= '0;
    end else if (beat_vld) begin
      for (int l = 0; l < int'(LANES); l++) acc[sel_delay][l] <= new_acc[l];
    end
  end

  // Result register: data only changes on end beats.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_vld    <= 1'b0;
      res_sel    <= '0;
      res_is_max <= 1'b0;
      res_data   <= '0;
    end else begin
      res_vld <= beat_end;
      if (beat_end) begin
        res_sel    <= sel_delay;
        res_is_max <= cmd_q[CMD_MAX];
        for (int l = 0; l < int'(LANES); l++) res_data[l*ACC_W +: ACC_W] <= new_acc[l];
      end
    end
  end

`ifdef POOL_PE_OUT_REG_EN
  // Extra retiming stage for the high-performance builds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_vld    <= 1'b0;
      out_sel    <= '0;
      out_is_max <= 1'b0;
      out_data   <= '0;
    end else begin
      out_vld    <= res_vld;
      out_sel    <= res_sel;
      out_is_max <= res_is_max;
      out_data   <= res_data;
    end
  end
`else
  assign out_vld    = res_vld;
  assign out_sel    = res_sel;
  assign out_is_max = res_is_max;
  assign out_data   = res_data;
`endif

endmodule

// File: tb/tb_pool_pe_row.sv
// Bench for pool_pe_row: per-slot/per-lane integer model plus a queue of
// expected results keyed by the cycle they must appear in.

module tb_pool_pe_row;

  localparam int LANES = 16;
  localparam int SLOTS = 4;
  localparam int ACC_W = 24;
  localparam int SEL_W = 2;
  localparam int DW    = LANES * ACC_W;
`ifdef POOL_PE_OUT_REG_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  typedef struct {
    int                cyc;
    int                sel;
    logic              is_max;
    logic [DW-1:0]     data;
  } exp_t;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [LANES*8-1:0]    xs = '0;
  logic [3:0]            cmd = '0;
  logic [SEL_W-1:0]      sel = '0;
  logic [SEL_W-1:0]      sel_delay = '0;
  logic                  out_vld;
  logic [SEL_W-1:0]      out_sel;
  logic                  out_is_max;
  logic [DW-1:0]         out_data;

  pool_pe_row #(.LANES(LANES), .SLOTS(SLOTS), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst), .xs(xs), .cmd(cmd), .sel(sel), .sel_delay(sel_delay),
    .out_vld(out_vld), .out_sel(out_sel), .out_is_max(out_is_max), .out_data(out_data)
  );

  always #5 clk = ~clk;

  int            cyc = 0;
  int            checks = 0;
  int            errors = 0;
  bit            chk_en = 1'b0;
  exp_t          exp_q[$];
  exp_t          e_cur;
  int            m_acc [SLOTS][LANES];
  logic [SEL_W-1:0] prev_sel = '0;
  logic [DW-1:0] res_data [SLOTS];
  int            res_cyc  [SLOTS];
  logic          res_max  [SLOTS];
  logic [DW-1:0] saved    [SLOTS];
  logic [LANES*8-1:0] d4  [12];
  int            end_cyc;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int wrap(input longint v);
    logic [ACC_W-1:0] t;
    t = v[ACC_W-1:0];
    return int'($signed(t));
  endfunction

  function automatic logic [LANES*8-1:0] rnd_x();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Drive one cycle of stimulus and update the model; returns at posedge+1.
  task automatic beat(input logic [3:0] c, input int s, input logic [LANES*8-1:0] x);
    exp_t e;
    int   xv;
    cmd       = c;
    sel       = SEL_W'(s);
    sel_delay = prev_sel;
    xs        = x;
    prev_sel  = SEL_W'(s);
    if (c[2] | c[1]) begin
      e.data = '0;
      for (int l = 0; l < LANES; l++) begin
        xv = int'($signed(x[l*8 +: 8]));
        if (c[0])      m_acc[s][l] = xv;
        else if (c[2]) m_acc[s][l] = (m_acc[s][l] > xv) ? m_acc[s][l] : xv;
        else           m_acc[s][l] = wrap(longint'(m_acc[s][l]) + longint'(xv));
        e.data[l*ACC_W +: ACC_W] = ACC_W'(m_acc[s][l]);
      end
      if (c[3]) begin
        e.cyc = cyc + LAT; e.sel = s; e.is_max = c[2];
        exp_q.push_back(e);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) beat(4'b0000, int'(prev_sel), '0);
  endtask

  task automatic clear_res();
    for (int s = 0; s < SLOTS; s++) begin res_cyc[s] = -1; res_data[s] = '0; res_max[s] = 1'b0; end
  endtask

  // Vector of 'n' elements over all slots; op is 4'b0100 (max) or 4'b0010 (avg).
  function automatic logic [3:0] vcmd(input logic [3:0] op, input int j, input int n);
    return op | {(j == n - 1), 3'b000} | {3'b000, (j == 0)};
  endfunction

  task automatic run4(input bit gaps);
    for (int k = 0; k < 12; k++) begin
      if (gaps) begin
        int g = $urandom_range(0, 2);
        for (int i = 0; i < g; i++)
          beat({1'($urandom_range(0, 1)), 2'b00, 1'($urandom_range(0, 1))}, int'(prev_sel), rnd_x());
      end
      beat(vcmd(4'b0100, k / 4, 3), k % 4, d4[k]);
    end
    idle(5);
  endtask

  // Compare process: every cycle either the expected result or no pulse.
  always @(negedge clk) begin
    if (chk_en) begin
      if (out_vld) begin
        res_data[out_sel] = out_data; res_cyc[out_sel] = cyc; res_max[out_sel] = out_is_max;
      end
      if (exp_q.size() != 0 && exp_q[0].cyc == cyc) begin
        e_cur = exp_q.pop_front();
        chk("out_vld", DW'(out_vld), DW'(1'b1));
        chk("out_sel", DW'(out_sel), DW'(e_cur.sel));
        chk("out_is_max", DW'(out_is_max), DW'(e_cur.is_max));
        chk("out_data", out_data, e_cur.data);
      end else begin
        chk("out_vld_idle", DW'(out_vld), DW'(1'b0));
      end
    end
  end

  initial begin
    logic [LANES*8-1:0] x;
    logic [7:0] t1 [3];
    logic [7:0] t2 [3];
    t1[0] = 8'hFB; t1[1] = 8'h07; t1[2] = 8'h02;   // -5, 7, 2
    t2[0] = 8'h64; t2[1] = 8'h64; t2[2] = 8'h80;   // 100, 100, -128
    for (int s = 0; s < SLOTS; s++) for (int l = 0; l < LANES; l++) m_acc[s][l] = 0;
    clear_res();

    // Reset state
    #2;
    chk("rst_out_vld", DW'(out_vld), '0);
    chk("rst_out_sel", DW'(out_sel), '0);
    chk("rst_out_is_max", DW'(out_is_max), '0);
    chk("rst_out_data", out_data, '0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    chk_en = 1'b1;
    idle(2);

    // Test 1: maxp, vector of 3, lane0 slot0 = -5, 7, 2
    clear_res();
    for (int j = 0; j < 3; j++)
      for (int s = 0; s < SLOTS; s++) begin
        x = rnd_x();
        if (s == 0) begin x[7:0] = t1[j]; if (j == 2) end_cyc = cyc; end
        beat(vcmd(4'b0100, j, 3), s, x);
      end
    idle(5);
    chk("t1_lane0", DW'(res_data[0][ACC_W-1:0]), DW'(24'd7));
    chk("t1_is_max", DW'(res_max[0]), DW'(1'b1));
    chk("t1_latency", DW'(res_cyc[0]), DW'(end_cyc + LAT));

    // Test 2: avgp, lane0 slot1 = 100, 100, -128
    clear_res();
    for (int j = 0; j < 3; j++)
      for (int s = 0; s < SLOTS; s++) begin
        x = rnd_x();
        if (s == 1) x[7:0] = t2[j];
        beat(vcmd(4'b0010, j, 3), s, x);
      end
    idle(5);
    chk("t2_lane0", DW'(res_data[1][ACC_W-1:0]), DW'(24'd72));
    chk("t2_is_max", DW'(res_max[1]), DW'(1'b0));
    chk("t2_slot2_next", DW'(res_cyc[2]), DW'(res_cyc[1] + 1));
    chk("t2_slot3_next", DW'(res_cyc[3]), DW'(res_cyc[1] + 2));

    // Test 3: vector size 1, start|end|max every beat, lane3 = -1
    clear_res();
    for (int k = 0; k < 8; k++) begin
      x = rnd_x();
      x[3*8 +: 8] = 8'hFF;
      beat(4'b1101, k % SLOTS, x);
    end
    idle(4);
    chk("t3_lane3_s0", DW'(res_data[0][3*ACC_W +: ACC_W]), DW'(24'hFFFFFF));
    chk("t3_lane3_s3", DW'(res_data[3][3*ACC_W +: ACC_W]), DW'(24'hFFFFFF));

    // Test 4: same maxp vector with and without idle gaps
    for (int k = 0; k < 12; k++) d4[k] = rnd_x();
    d4[0][7:0] = 8'h80; d4[4][7:0] = 8'h80; d4[8][7:0] = 8'h81;   // boundary: -128,-128,-127
    clear_res();
    run4(1'b0);
    for (int s = 0; s < SLOTS; s++) saved[s] = res_data[s];
    chk("t4_lane0_min", DW'(saved[0][ACC_W-1:0]), DW'(24'hFFFF81));
    clear_res();
    run4(1'b1);
    for (int s = 0; s < SLOTS; s++) chk("t4_gap_equal", res_data[s], saved[s]);

    // Test 5: reset between edges in the middle of a vector
    for (int s = 0; s < SLOTS; s++) beat(vcmd(4'b0010, 0, 2), s, rnd_x());
    beat(vcmd(4'b0010, 1, 2), 0, rnd_x());
    beat(vcmd(4'b0010, 1, 2), 1, rnd_x());
    chk_en = 1'b0;
    #3 rst = 1'b1;
    #1;
    chk("t5_rst_out_vld", DW'(out_vld), '0);
    chk("t5_rst_out_sel", DW'(out_sel), '0);
    chk("t5_rst_out_is_max", DW'(out_is_max), '0);
    chk("t5_rst_out_data", out_data, '0);
    exp_q.delete();
    cmd = '0; sel = '0; sel_delay = '0; prev_sel = '0;
    for (int s = 0; s < SLOTS; s++) for (int l = 0; l < LANES; l++) m_acc[s][l] = 0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    chk_en = 1'b1;
    clear_res();
    for (int j = 0; j < 2; j++)
      for (int s = 0; s < SLOTS; s++) begin
        x = rnd_x();
        if (s == 0) x[7:0] = (j == 0) ? 8'd10 : 8'd20;
        beat(vcmd(4'b0010, j, 2), s, x);
      end
    idle(5);
    chk("t5_restart_lane0", DW'(res_data[0][ACC_W-1:0]), DW'(24'd30));

    chk("queue_drained", DW'(exp_q.size()), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
